// File: rtl/uart_tx_frame_if.sv
// Valid/ready word handshake between a byte source and the UART transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits.
// Words arrive over a valid/ready handshake; bit timing comes from an internal divider.
module uart_tx_frame #(
    parameter int BAUD      = 9600,
    parameter int F         = 50000000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_frame_if.slave bus,
    output logic          tx,
    output logic          busy,
    output logic          done
);

    localparam int DIV   = (F + BAUD / 2) / BAUD;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
        $error("uart_tx_frame: illegal DATA_BITS/PARITY/STOP_BITS combination");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY_BIT,
        STOP
    } state_t;

    state_t               state_reg;
    logic [DIV_W-1:0]     div_cnt_reg;
    logic [BIT_W-1:0]     bit_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity_reg;
    logic                 tx_reg;
    logic                 done_reg;
    logic                 div_last;

    assign div_last  = (div_cnt_reg == DIV_W'(DIV - 1));
    assign bus.ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign tx        = tx_reg;
    assign done      = done_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            div_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            tx_reg      <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    div_cnt_reg <= '0;
                    bit_idx_reg <= '0;
                    tx_reg      <= 1'b1;
                    if (bus.valid) begin
                        shift_reg  <= bus.data;
                        // Odd parity is the inverted XOR so the total count of ones is odd.
                        parity_reg <= (PARITY == 1) ? ~(^bus.data) : (^bus.data);
                        state_reg  <= START;
                        tx_reg     <= 1'b0;
                    end
                end
                START: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        tx_reg      <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                        state_reg   <= DATA;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                DATA: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        if (bit_idx_reg == BIT_W'(DATA_BITS - 1)) begin
                            bit_idx_reg <= '0;
                            if (PARITY != 0) begin
                                tx_reg    <= parity_reg;
                                state_reg <= PARITY_BIT;
                            end else begin
                                tx_reg    <= 1'b1;
                                state_reg <= STOP;
                            end
                        end else begin
                            bit_idx_reg <= bit_idx_reg + BIT_W'(1);
                            tx_reg      <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                PARITY_BIT: begin
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        tx_reg      <= 1'b1;
                        state_reg   <= STOP;
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                STOP: begin
                    // bit_idx_reg is reused to count stop bits.
                    if (div_last) begin
                        div_cnt_reg <= '0;
                        if (bit_idx_reg == BIT_W'(STOP_BITS - 1)) begin
                            bit_idx_reg <= '0;
                            done_reg    <= 1'b1;
                            state_reg   <= IDLE;
                        end else begin
                            bit_idx_reg <= bit_idx_reg + BIT_W'(1);
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

endmodule
